ctrl_sequencer: RTL and testbench

Two-phase control sequencer for the 4-bit processor. Alternates FETCH/EXEC, decodes the 4-bit opcode from the fetch register, and drives the strobes for the rest of the datapath: program counter, accumulator, ALU select, input-bus select, and `out_en`, the load enable of the 4-bit output register. It owns the carry/zero flags register used by conditional jumps. It sits directly upstream of the output register and supplies its enable.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/ctrl_flags.sv | 25 ++
 rtl/ctrl_sequencer.sv | 105 ++++++++++
 tb/tb_ctrl_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor: opcodes, ALU select codes and
// the control sequencer state encoding.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JNC  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_NOPE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      default: alu_code = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_flags.sv
// Carry/zero flags register: {carry, zero}, loaded when load is high.
module ctrl_flags (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] flags_q;
  logic [1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (load) flags_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 2'b00;
    else       flags_q <= flags_d;
  end

  assign q = flags_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Two-phase FETCH/EXEC control sequencer with combinational strobe decode.
// Optional HALT state for opcode F is built when CTRL_HALT_EN is defined.
module ctrl_sequencer
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enabled,
  input  logic [3:0] instr,
  input  logic       c_in,
  input  logic       z_in,
  output logic       phase,
  output logic       fetch_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_en,
  output logic [2:0] alu_sel,
  output logic       in_oe,
  output logic       out_en,
  output logic       c_flag,
  output logic       z_flag,
  output logic       halted
);

  state_t     state_q;
  state_t     state_d;
  logic       flags_load;
  logic [1:0] flags_q;

  always_comb begin
    state_d    = state_q;
    flags_load = 1'b0;
    fetch_en   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_en     = 1'b0;
    alu_sel    = ALU_PASS;
    in_oe      = 1'b0;
    out_en     = 1'b0;
    // Reset must silence the strobes even though state already reads FETCH.
    if (enabled && !reset) begin
      case (state_q)
        ST_FETCH: begin
          fetch_en = 1'b1;
          pc_inc   = 1'b1;
          state_d  = ST_EXEC;
        end
        ST_EXEC: begin
          state_d = ST_FETCH;
          case (instr)
            OP_LIT: acc_en = 1'b1;
            OP_IN: begin
              acc_en = 1'b1;
              in_oe  = 1'b1;
            end
            OP_OUT: out_en = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              acc_en     = 1'b1;
              alu_sel    = alu_code(instr);
              flags_load = 1'b1;
            end
            OP_CMP: begin
              alu_sel    = ALU_SUB;
              flags_load = 1'b1;
            end
            OP_JMP: pc_load = 1'b1;
            OP_JC:  pc_load = flags_q[1];
            OP_JNC: pc_load = ~flags_q[1];
            OP_JZ:  pc_load = flags_q[0];
            OP_JNZ: pc_load = ~flags_q[0];
`ifdef CTRL_HALT_EN
            OP_HALT: state_d = ST_HALT;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  ctrl_flags u_flags (
    .clk   (clk),
    .reset (reset),
    .load  (flags_load),
    .d     ({c_in, z_in}),
    .q     (flags_q)
  );

  assign phase  = (state_q == ST_EXEC);
  assign c_flag = flags_q[1];
  assign z_flag = flags_q[0];

`ifdef CTRL_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed and randomized bench for ctrl_sequencer against an instruction-level model.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enabled = 1'b0;
  logic [3:0] instr = 4'h0;
  logic       c_in = 1'b0;
  logic       z_in = 1'b0;
  logic       phase, fetch_en, pc_inc, pc_load, acc_en, in_oe, out_en;
  logic       c_flag, z_flag, halted;
  logic [2:0] alu_sel;

  logic [3:0] out_d = 4'h0;
  logic [3:0] out_q = 4'h0;

  int checks = 0;
  int errors = 0;

  // Model: what instruction step the processor is in, plus its flags.
  int         m_step = 0;    // 0 fetch, 1 exec, 2 halted
  bit         m_c = 0;
  bit         m_z = 0;
  logic [3:0] m_out = 4'h0;

`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  ctrl_sequencer dut (
    .clk(clk), .reset(reset), .enabled(enabled), .instr(instr),
    .c_in(c_in), .z_in(z_in), .phase(phase), .fetch_en(fetch_en),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_en(acc_en), .alu_sel(alu_sel),
    .in_oe(in_oe), .out_en(out_en), .c_flag(c_flag), .z_flag(z_flag),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_en) out_q <= out_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // {pc_load, acc_en, alu_sel, in_oe, out_en} for an executed opcode.
  function automatic logic [6:0] exec_bundle(input logic [3:0] op, input bit c, input bit z);
    case (op)
      4'h1: return 7'b0_1_000_0_0;              // LIT
      4'h2: return 7'b0_1_000_1_0;              // IN
      4'h3: return 7'b0_0_000_0_1;              // OUT
      4'h4: return 7'b0_1_001_0_0;              // ADD
      4'h5: return 7'b0_1_010_0_0;              // SUB
      4'h6: return 7'b0_1_011_0_0;              // AND
      4'h7: return 7'b0_1_100_0_0;              // OR
      4'h8: return 7'b0_0_010_0_0;              // CMP
      4'h9: return 7'b1_0_000_0_0;              // JMP
      4'hA: return {c,  6'b0};                  // JC
      4'hB: return {!c, 6'b0};                  // JNC
      4'hC: return {z,  6'b0};                  // JZ
      4'hD: return {!z, 6'b0};                  // JNZ
      default: return 7'b0;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input bit r, input bit e, input logic [3:0] i, input bit c, input bit z);
    logic [13:0] exp_v, got_v;
    logic [6:0]  eb;
    bit          fe;
    @(posedge clk);
    #1;
    reset = r; enabled = e; instr = i; c_in = c; z_in = z;
    out_d = 4'($urandom_range(15));
    if (r) begin
      m_step = 0; m_c = 0; m_z = 0;
    end
    #1;
    fe = 0; eb = 7'b0;
    if (!r && e && m_step == 0) fe = 1;
    if (!r && e && m_step == 1) eb = exec_bundle(i, m_c, m_z);
    exp_v = {m_step == 1, fe, fe, eb[6], eb[5], eb[4:2], eb[1], eb[0], m_c, m_z, m_step == 2};
    got_v = {phase, fetch_en, pc_inc, pc_load, acc_en, alu_sel, in_oe, out_en, c_flag, z_flag, halted};
    check($sformatf("outputs op=%h en=%0d rst=%0d", i, e, r), 32'(got_v), 32'(exp_v));
    check("pc_excl", 32'(pc_inc & pc_load), 32'd0);
    check("out_reg", 32'(out_q), 32'(m_out));
    if (eb[0]) m_out = out_d;
    if (!r && e) begin
      if (m_step == 0) m_step = 1;
      else if (m_step == 1) begin
        if (i >= 4'h4 && i <= 4'h8) begin
          m_c = c; m_z = z;
        end
        m_step = (i == 4'hF && HALT_EN) ? 2 : 0;
      end
    end
  endtask

  initial begin
    // Reset, then OUT.
    step(1, 0, 4'h0, 0, 0);
    step(1, 1, 4'h3, 1, 1);
    step(0, 1, 4'h0, 0, 0);
    step(0, 1, 4'h3, 0, 0);
    // ADD sets both flags, then JZ taken and JNZ not.
    step(0, 1, 4'h0, 0, 0);
    step(0, 1, 4'h4, 1, 1);
    step(0, 1, 4'h0, 0, 0);
    step(0, 1, 4'hC, 0, 0);
    step(0, 1, 4'h0, 0, 0);
    step(0, 1, 4'hD, 0, 0);
    // Enable dropped for three cycles during EXEC of LIT.
    step(0, 1, 4'h0, 0, 0);
    step(0, 0, 4'h1, 0, 0);
    step(0, 0, 4'h1, 0, 0);
    step(0, 0, 4'h1, 0, 0);
    step(0, 1, 4'h1, 0, 0);
    // Reset during EXEC of SUB.
    step(0, 1, 4'h0, 0, 0);
    step(1, 1, 4'h5, 1, 1);
    step(0, 1, 4'h5, 1, 1);
    step(0, 1, 4'h5, 1, 1);
    // Opcode F, then a long idle stretch.
    step(0, 1, 4'hF, 0, 0);
    for (int k = 0; k < 12; k++) step(0, 1, 4'(k), 1, 0);
    step(1, 1, 4'h0, 0, 0);
    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(39) == 0, $urandom_range(4) != 0,
           4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
